// File: rtl/multdiv_pkg.sv
// Shared constants and state type for the multdiv unit (multiplier and divider).
package multdiv_pkg;
  localparam int WIDTH     = 32;
  localparam int DIV_ITERS = 32;

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_e;
endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the stall logic (master) and the divider (slave).
// The remainder signal exists only when DIV_REMAINDER_EN is defined.
interface div_seq_if;
  import multdiv_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] quotient;
  logic             exception;
`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] remainder;

  modport master (output start, dividend, divisor,
                  input  busy, ready, quotient, exception, remainder);
  modport slave  (input  start, dividend, divisor,
                  output busy, ready, quotient, exception, remainder);
`else
  modport master (output start, dividend, divisor,
                  input  busy, ready, quotient, exception);
  modport slave  (input  start, dividend, divisor,
                  output busy, ready, quotient, exception);
`endif
endinterface

// File: rtl/cla_full_adder.sv
// Generate/propagate carry adder: sum = a + b + cin, cout is the carry out of the MSB.
// Purely combinational.
module cla_full_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];
endmodule

// File: rtl/div_step.sv
// One combinational restoring-division iteration on {R, Q}: shift left, trial-subtract
// the divisor magnitude, keep the difference and set Q[0] when it does not borrow.
module div_step
  import multdiv_pkg::*;
(
  input  logic [2*WIDTH:0] rq_in,
  input  logic [WIDTH-1:0] dmag,
  output logic [2*WIDTH:0] rq_out
);
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;
  logic           no_borrow;
  logic           rq_msb_unused;

  // R stays below |divisor| <= 2^31, so its top bit is always shifted out as zero.
  assign rq_msb_unused = rq_in[2*WIDTH];
  assign r_sh          = rq_in[2*WIDTH-1:WIDTH-1];

  // Carry out of R + ~D + 1 is set exactly when R >= D.
  cla_full_adder #(.N(WIDTH+1)) u_sub (
    .a   (r_sh),
    .b   (~{1'b0, dmag}),
    .cin (1'b1),
    .sum (diff),
    .cout(no_borrow)
  );

  assign rq_out = {(no_borrow ? diff : r_sh), rq_in[WIDTH-2:0], no_borrow};
endmodule

// File: rtl/div_seq.sv
// 32-bit signed restoring divider, fixed 33 cycles start-to-ready; start is ignored while busy.
// Flags divide-by-zero and INT_MIN/-1; remainder port only with DIV_REMAINDER_EN.
module div_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  div_seq_if.slave    bus
);
  localparam int CNT_W = $clog2(DIV_ITERS);

  div_state_e         state, state_nxt;
  logic               load, step_en, fix_en;
  logic [2*WIDTH:0]   rq, rq_step;
  logic [WIDTH-1:0]   dmag, amag, bmag;
  logic               sign_q, sign_r, dz, ov;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   quot_q, quot_nxt, neg_q;
  logic               exc_q;
  logic               neg_q_cout_unused;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step_en   = 1'b0;
    fix_en    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        step_en = 1'b1;
        if (cnt == CNT_W'(DIV_ITERS - 1)) state_nxt = FIX;
      end
      FIX: begin
        fix_en    = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // INT_MIN has no positive counterpart; its magnitude is read back as unsigned 2^31.
  assign amag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign bmag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

  div_step u_step (
    .rq_in (rq),
    .dmag  (dmag),
    .rq_out(rq_step)
  );

  cla_full_adder #(.N(WIDTH)) u_neg_q (
    .a   (~rq[WIDTH-1:0]),
    .b   ('0),
    .cin (1'b1),
    .sum (neg_q),
    .cout(neg_q_cout_unused)
  );

  always_comb begin
    quot_nxt = sign_q ? neg_q : rq[WIDTH-1:0];
    if (dz)      quot_nxt = '0;
    else if (ov) quot_nxt = INT_MIN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rq     <= '0;
      dmag   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz     <= 1'b0;
      ov     <= 1'b0;
      cnt    <= '0;
      quot_q <= '0;
      exc_q  <= 1'b0;
    end else begin
      if (load) begin
        rq     <= {{(WIDTH+1){1'b0}}, amag};
        dmag   <= bmag;
        sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
        sign_r <= bus.dividend[WIDTH-1];
        dz     <= (bus.divisor == '0);
        ov     <= (bus.dividend == INT_MIN) && (bus.divisor == NEG_ONE);
        cnt    <= '0;
      end else if (step_en) begin
        rq  <= rq_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (fix_en) begin
        quot_q <= quot_nxt;
        exc_q  <= dz | ov;
      end
    end
  end

`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] rem_q, neg_r;
  logic             neg_r_cout_unused;

  cla_full_adder #(.N(WIDTH)) u_neg_r (
    .a   (~rq[2*WIDTH-1:WIDTH]),
    .b   ('0),
    .cin (1'b1),
    .sum (neg_r),
    .cout(neg_r_cout_unused)
  );

  // With a zero divisor every trial subtract succeeds, so R ends as |dividend|
  // and the normal sign fix already yields remainder == dividend.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rem_q <= '0;
    else if (fix_en) rem_q <= sign_r ? neg_r : rq[2*WIDTH-1:WIDTH];
  end

  assign bus.remainder = rem_q;
`endif

  assign bus.busy      = (state == RUN) || (state == FIX);
  assign bus.ready     = (state == DONE);
  assign bus.quotient  = quot_q;
  assign bus.exception = exc_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed plus randomized bench for div_seq against an arithmetic reference model.
module tb_div_seq;
  import multdiv_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  div_seq_if dif();

  div_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic e);
    int sa, sb;
    sa = a;
    sb = b;
    if (sb == 0) begin
      q = 32'd0; r = a; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; e = 1'b1;
    end else begin
      q = sa / sb; r = sa % sb; e = 1'b0;
    end
  endfunction

  // Called at a negedge; returns at the negedge right after the start edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = $urandom();
    dif.divisor  = $urandom();
  endtask

  // Waits for ready (bounded), optionally poking start while busy, then checks results.
  task automatic finish_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int poke_at);
    int k = 0;
    logic [31:0] eq, er;
    logic ee;
    model(a, b, eq, er, ee);
    check({tag, ":busy"}, 32'(dif.busy), 32'd1);
    while (!dif.ready && k < 40) begin
      dif.start = (k == poke_at);
      if (k == poke_at) begin
        dif.dividend = 32'd1;
        dif.divisor  = 32'd1;
      end
      @(negedge clk);
      k++;
    end
    dif.start = 1'b0;
    check({tag, ":latency"}, 32'(k), 32'd33);
    check({tag, ":quotient"}, dif.quotient, eq);
    check({tag, ":exception"}, 32'(dif.exception), 32'(ee));
    check({tag, ":busy_done"}, 32'(dif.busy), 32'd0);
`ifdef DIV_REMAINDER_EN
    check({tag, ":remainder"}, dif.remainder, er);
`endif
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, ":ready_drop"}, 32'(dif.ready), 32'd0);
    check({tag, ":idle"}, 32'(dif.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int pulses;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst:busy", 32'(dif.busy), 32'd0);
    check("rst:ready", 32'(dif.ready), 32'd0);
    check("rst:quotient", dif.quotient, 32'd0);
    check("rst:exception", 32'(dif.exception), 32'd0);
`ifdef DIV_REMAINDER_EN
    check("rst:remainder", dif.remainder, 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    launch(32'd100, 32'd7);                    finish_op("p100_7", 32'd100, 32'd7, -1);
    check_idle("p100_7");
    launch(32'hFFFF_FF9C, 32'd7);              finish_op("m100_7", 32'hFFFF_FF9C, 32'd7, -1);
    check_idle("m100_7");
    launch(32'd5, 32'd0);                      finish_op("dz", 32'd5, 32'd0, -1);
    check_idle("dz");
    launch(INT_MIN, NEG_ONE);                  finish_op("ov", INT_MIN, NEG_ONE, -1);
    check_idle("ov");
    launch(INT_MIN, 32'd2);                    finish_op("min_2", INT_MIN, 32'd2, -1);
    // Restart during the DONE cycle, with a stray start mid-run.
    launch(32'd7, 32'hFFFF_FFFE);              finish_op("b2b_7_m2", 32'd7, 32'hFFFF_FFFE, 10);
    check_idle("b2b_7_m2");

    // Abort by reset partway through a division.
    launch(32'd100, 32'd7);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort:busy", 32'(dif.busy), 32'd0);
    check("abort:ready", 32'(dif.ready), 32'd0);
    check("abort:quotient", dif.quotient, 32'd0);
    check("abort:exception", 32'(dif.exception), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready) pulses++;
    end
    check("abort:no_ready", 32'(pulses), 32'd0);
    launch(32'd100, 32'd7);                    finish_op("post_abort", 32'd100, 32'd7, -1);
    check_idle("post_abort");

    for (int i = 0; i < 24; i++) begin
      a = $urandom();
      case (i % 4)
        0:       b = $urandom();
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        default: b = (i % 8 == 3) ? 32'd0 : ($urandom() >> $urandom_range(0, 31));
      endcase
      if (i % 6 == 5) a = INT_MIN;
      launch(a, b);
      finish_op($sformatf("rnd%0d", i), a, b, (i % 5 == 0) ? 5 : -1);
      if (i % 3 == 0) check_idle($sformatf("rnd%0d", i));
    end
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
